// File: rtl/shifter_pkg.sv
// shifter_pkg: shared types and helpers for the pipelined barrel shifter.
//   shift_cmd_e   - decoded shift operation
//   payload_t     - per-stage payload (data, remaining amount, cmd, word, tag),
//                   sized for the widest configuration (XLEN=64, TAG_W<=16);
//                   narrower builds use the low bits of each field
//   levels_in_stage / first_level - split of the log2(XLEN) shift levels
//                   across the register stages
package shifter_pkg;

  localparam int MAX_XLEN  = 64;
  localparam int MAX_AMT_W = 6;
  localparam int MAX_TAG_W = 16;

  typedef enum logic [2:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_cmd_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0]  data;
    logic [MAX_AMT_W-1:0] amt;
    shift_cmd_e           cmd;
    logic                 word;
    logic [MAX_TAG_W-1:0] tag;
  } payload_t;

  // The first (L mod stages) stages take one extra level.
  function automatic int levels_in_stage(int xlen, int stages, int s);
    int l;
    l = $clog2(xlen);
    return (l / stages) + ((s < (l % stages)) ? 1 : 0);
  endfunction

  // Global index (0 = largest distance) of the first level held by stage s.
  function automatic int first_level(int xlen, int stages, int s);
    int acc;
    acc = 0;
    for (int i = 0; i < s; i++) acc += levels_in_stage(xlen, stages, i);
    return acc;
  endfunction

endpackage

// File: rtl/shifter_level.sv
// shifter_level: one conditional shift level of distance DIST. Purely
// combinational. When en is low the operand passes through unchanged.
// Ports:
//   din  - operand in
//   en   - amount bit selecting this level
//   cmd  - decoded operation (ROL/ROR only reach here in rotate builds)
//   dout - operand after this level
// Build option: SHIFTER_ROTATE_EN adds the wrap-around paths.
module shifter_level
  import shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DIST = 1
) (
  input  logic [XLEN-1:0] din,
  input  logic            en,
  input  shift_cmd_e      cmd,
  output logic [XLEN-1:0] dout
);

  always_comb begin
    dout = din;
    if (en) begin
      case (cmd)
        SRL:     dout = {{DIST{1'b0}}, din[XLEN-1:DIST]};
        // Bit XLEN-1 carries the sign; W-op operands arrive pre-sign-extended.
        SRA:     dout = {{DIST{din[XLEN-1]}}, din[XLEN-1:DIST]};
`ifdef SHIFTER_ROTATE_EN
        ROL:     dout = {din[XLEN-DIST-1:0], din[XLEN-1:XLEN-DIST]};
        ROR:     dout = {din[DIST-1:0], din[XLEN-1:DIST]};
`endif
        default: dout = {din[XLEN-DIST-1:0], {DIST{1'b0}}};
      endcase
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined XLEN-wide barrel shifter (SLL/SRL/SRA, optional
// ROL/ROR, RV64 W variants) with STAGES register stages.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   FLUSH_SE      - drop everything in flight (and any offered input)
//   IN_VALID_SE / IN_READY_SE - request handshake
//   DIN_SE, SHIFT_VAL_SE, CMD_SE, WORD_SE, TAG_SE - request payload
//   OUT_VALID_SE / OUT_READY_SE - result handshake
//   DOUT_SE, TAG_OUT_SE - result and its tag (registered)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds valid and payload until that edge, and a stalled
// result (valid && !ready) keeps DOUT_SE/TAG_OUT_SE stable.
// Build option: SHIFTER_ROTATE_EN enables ROL/ROR; otherwise CMD 3 acts as
// SLL and CMD 4 as SRL. TAG_W must not exceed 16.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     FLUSH_SE,
  input  logic                     IN_VALID_SE,
  output logic                     IN_READY_SE,
  input  logic [XLEN-1:0]          DIN_SE,
  input  logic [$clog2(XLEN)-1:0]  SHIFT_VAL_SE,
  input  logic [2:0]               CMD_SE,
  input  logic                     WORD_SE,
  input  logic [TAG_W-1:0]         TAG_SE,
  output logic                     OUT_VALID_SE,
  input  logic                     OUT_READY_SE,
  output logic [XLEN-1:0]          DOUT_SE,
  output logic [TAG_W-1:0]         TAG_OUT_SE
);

  localparam int L = $clog2(XLEN);

  // ---------------------------------------------------------------- decode
  shift_cmd_e      in_cmd;
  logic            word_op;
  logic [L-1:0]    in_amt;
  logic [63:0]     w64;
  payload_t        in_pay;
  logic            accept;

  always_comb begin
    case (CMD_SE)
      3'd1:    in_cmd = SRL;
      3'd2:    in_cmd = SRA;
`ifdef SHIFTER_ROTATE_EN
      3'd3:    in_cmd = ROL;
      3'd4:    in_cmd = ROR;
`else
      3'd4:    in_cmd = SRL;
`endif
      default: in_cmd = SLL;
    endcase
  end

  assign word_op = WORD_SE && (XLEN == 64);

  // W-op operand shaping so a full-width shift yields the 32-bit answer in
  // the low word: zero-extend for logical, sign-extend for SRA, duplicate
  // the word for rotates so the wrapped bits land in the low half.
  always_comb begin
    case (in_cmd)
      SRA:      w64 = {{32{DIN_SE[31]}}, DIN_SE[31:0]};
      ROL, ROR: w64 = {DIN_SE[31:0], DIN_SE[31:0]};
      default:  w64 = {32'b0, DIN_SE[31:0]};
    endcase
  end

  always_comb begin
    in_amt = SHIFT_VAL_SE;
    if (word_op) in_amt[L-1] = 1'b0;
    in_pay      = '0;
    in_pay.data = MAX_XLEN'(word_op ? w64[XLEN-1:0] : DIN_SE);
    in_pay.amt  = MAX_AMT_W'(in_amt);
    in_pay.cmd  = in_cmd;
    in_pay.word = word_op;
    in_pay.tag  = MAX_TAG_W'(TAG_SE);
  end

  // ------------------------------------------------------- valid/ready chain
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  payload_t          stage_q [STAGES];

  // ld[s]: stage s may take new content this edge. True when the output is
  // being consumed or any stage from s downstream is empty (bubbles collapse).
  always_comb begin
    logic acc;
    acc = OUT_READY_SE;
    for (int s = STAGES - 1; s >= 0; s--) begin
      acc   = acc | ~vld[s];
      ld[s] = acc;
    end
  end

  assign IN_READY_SE = !FLUSH_SE && ld[0];
  assign accept      = IN_VALID_SE && IN_READY_SE;

  // ------------------------------------------------------------------ stages
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int NLV = levels_in_stage(XLEN, STAGES, s);
    localparam int FL  = first_level(XLEN, STAGES, s);

    payload_t        src;
    logic            src_v;
    payload_t        nxt;
    payload_t        pay_q;
    logic            v_q;
    logic [XLEN-1:0] chain [NLV+1];

    if (s == 0) begin : g_src_in
      assign src   = in_pay;
      assign src_v = accept;
    end else begin : g_src_prev
      assign src   = stage_q[s-1];
      assign src_v = vld[s-1];
    end

    assign chain[0] = src.data[XLEN-1:0];

    for (genvar k = 0; k < NLV; k++) begin : g_lvl
      localparam int LV = FL + k;
      shifter_level #(
        .XLEN (XLEN),
        .DIST (1 << (L - 1 - LV))
      ) u_level (
        .din  (chain[k]),
        .en   (src.amt[L-1-LV]),
        .cmd  (src.cmd),
        .dout (chain[k+1])
      );
    end

    // The W-op sign-extension is folded into the last stage's load.
    always_comb begin
      nxt      = src;
      nxt.data = MAX_XLEN'(chain[NLV]);
      if (s == STAGES - 1 && src.word)
        nxt.data = {{32{chain[NLV][31]}}, chain[NLV][31:0]};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q   <= 1'b0;
        pay_q <= '0;
      end else if (FLUSH_SE) begin
        v_q <= 1'b0;
      end else if (ld[s]) begin
        v_q <= src_v;
        if (src_v) pay_q <= nxt;
      end
    end

    assign vld[s]     = v_q;
    assign stage_q[s] = pay_q;
  end

  // ----------------------------------------------------------------- outputs
  assign OUT_VALID_SE = vld[STAGES-1];
  assign DOUT_SE      = stage_q[STAGES-1].data[XLEN-1:0];
  assign TAG_OUT_SE   = stage_q[STAGES-1].tag[TAG_W-1:0];

  // Fields of the output stage that no consumer reads.
  logic unused_ok;
  assign unused_ok = ^{stage_q[STAGES-1], w64};

endmodule

// File: tb/tb_shifter_pipe.sv
module tb_shifter_pipe;

  localparam int W = 37;  // {tag[4:0], data[31:0]}

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------- DUT 32 / 2
  logic        flush32, v32, rdy32, ov32, ordy32, word32;
  logic [31:0] din32, dout32;
  logic [4:0]  amt32, tag32, tago32;
  logic [2:0]  cmd32;

  shifter_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) u_dut32 (
    .clk          (clk),
    .reset        (reset),
    .FLUSH_SE     (flush32),
    .IN_VALID_SE  (v32),
    .IN_READY_SE  (rdy32),
    .DIN_SE       (din32),
    .SHIFT_VAL_SE (amt32),
    .CMD_SE       (cmd32),
    .WORD_SE      (word32),
    .TAG_SE       (tag32),
    .OUT_VALID_SE (ov32),
    .OUT_READY_SE (ordy32),
    .DOUT_SE      (dout32),
    .TAG_OUT_SE   (tago32)
  );

  // -------------------------------------------------------- DUT 64 / 3
  logic        flush64, v64, rdy64, ov64, ordy64, word64;
  logic [63:0] din64, dout64;
  logic [5:0]  amt64;
  logic [4:0]  tag64, tago64;
  logic [2:0]  cmd64;

  shifter_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5)) u_dut64 (
    .clk          (clk),
    .reset        (reset),
    .FLUSH_SE     (flush64),
    .IN_VALID_SE  (v64),
    .IN_READY_SE  (rdy64),
    .DIN_SE       (din64),
    .SHIFT_VAL_SE (amt64),
    .CMD_SE       (cmd64),
    .WORD_SE      (word64),
    .TAG_SE       (tag64),
    .OUT_VALID_SE (ov64),
    .OUT_READY_SE (ordy64),
    .DOUT_SE      (dout64),
    .TAG_OUT_SE   (tago64)
  );

  // ------------------------------------------------------------ scoreboard
  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [63:0]  exp64_q[$];
  int           pop_cyc[$];
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_val;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model32(input logic [31:0] x, input int n, input int c);
    logic [31:0] r;
    int cc;
    cc = (c > 4) ? 0 : c;
`ifndef SHIFTER_ROTATE_EN
    if (cc == 3) cc = 0;
    else if (cc == 4) cc = 1;
`endif
    case (cc)
      1:       r = x >> n;
      2:       r = $signed(x) >>> n;
      3:       r = (x << n) | (x >> (32 - n));
      4:       r = (x >> n) | (x << (32 - n));
      default: r = x << n;
    endcase
    return r;
  endfunction

  // Output monitor for the 32-bit DUT, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && ov32) check("hold_stable", 64'({tago32, dout32}), 64'(hold_val));
      if (ov32 && ordy32) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_out: got %h, expected no result", {tago32, dout32});
        end else begin
          check("result32", 64'({tago32, dout32}), 64'(exp_q.pop_front()));
          pop_cyc.push_back(cyc);
        end
      end
      hold_pend = ov32 && !ordy32;
      hold_val  = {tago32, dout32};
    end
  end

  // --------------------------------------------------------------- drivers
  task automatic send32(input logic [31:0] d, input logic [4:0] a, input logic [2:0] c,
                        input logic [4:0] t, input logic [31:0] e, input bit push);
    logic ok;
    int   g;
    v32 = 1'b1; din32 = d; amt32 = a; cmd32 = c; tag32 = t;
    g = 0;
    do begin
      @(negedge clk); ok = rdy32;
      @(posedge clk); #1; g++;
    end while (!ok && g < 50);
    v32 = 1'b0;
    if (!ok) check("accept32_timeout", 64'(ok), 64'd1);
    else if (push) exp_q.push_back({t, e});
  endtask

  task automatic drain32();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin @(posedge clk); #1; g++; end
    check("drain32", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run64(input string nm, input logic [63:0] d, input logic [5:0] a,
                       input logic [2:0] c, input logic w, input logic [4:0] t,
                       input logic [63:0] e);
    logic ok;
    int   g, lat;
    v64 = 1'b1; din64 = d; amt64 = a; cmd64 = c; word64 = w; tag64 = t;
    g = 0;
    do begin
      @(negedge clk); ok = rdy64;
      @(posedge clk); #1; g++;
    end while (!ok && g < 50);
    v64 = 1'b0;
    if (!ok) begin
      check({nm, "_accept"}, 64'(ok), 64'd1);
    end else begin
      exp64_q.push_back(e);
      lat = 0;
      while (!ov64 && lat < 10) begin @(posedge clk); #1; lat++; end
      check({nm, "_latency"}, 64'(lat), 64'd2);
      check(nm, dout64, exp64_q.pop_front());
      check({nm, "_tag"}, 64'(tago64), 64'(t));
      @(posedge clk); #1;
    end
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    logic [31:0] din;
    logic [4:0]  amt;
    logic [2:0]  cmd;
    logic [31:0] exp;
  } vec_t;

  vec_t tab [11];

  initial begin
    logic ok;
    int   g;
    logic [31:0] d, e;
    logic [4:0]  a;
    logic [2:0]  c;

    tab[0]  = '{32'h8000_0000, 5'd4,  3'd2, 32'hF800_0000};
    tab[1]  = '{32'h0000_0001, 5'd31, 3'd0, 32'h8000_0000};
    tab[2]  = '{32'h8000_0000, 5'd31, 3'd1, 32'h0000_0001};
    tab[3]  = '{32'h7FFF_FFFF, 5'd31, 3'd2, 32'h0000_0000};
    tab[4]  = '{32'hDEAD_BEEF, 5'd0,  3'd0, 32'hDEAD_BEEF};
`ifdef SHIFTER_ROTATE_EN
    tab[5]  = '{32'h1234_5678, 5'd8,  3'd4, 32'h7812_3456};
    tab[6]  = '{32'h1234_5678, 5'd4,  3'd3, 32'h2345_6781};
`else
    tab[5]  = '{32'h1234_5678, 5'd8,  3'd4, 32'h0012_3456};
    tab[6]  = '{32'h1234_5678, 5'd4,  3'd3, 32'h2345_6780};
`endif
    tab[7]  = '{32'h0000_000F, 5'd4,  3'd7, 32'h0000_00F0};
    tab[8]  = '{32'hF000_0000, 5'd0,  3'd2, 32'hF000_0000};
    tab[9]  = '{32'hFFFF_FFFF, 5'd16, 3'd1, 32'h0000_FFFF};
    tab[10] = '{32'h0000_0001, 5'd1,  3'd5, 32'h0000_0002};

    reset = 1'b1;
    flush32 = 0; v32 = 0; din32 = '0; amt32 = '0; cmd32 = '0; tag32 = '0; word32 = 0; ordy32 = 1;
    flush64 = 0; v64 = 0; din64 = '0; amt64 = '0; cmd64 = '0; tag64 = '0; word64 = 0; ordy64 = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_out_valid32", 64'(ov32), 64'd0);
    check("rst_dout32", 64'(dout32), 64'd0);
    check("rst_tag32", 64'(tago32), 64'd0);
    check("rst_in_ready32", 64'(rdy32), 64'd1);
    check("rst_out_valid64", 64'(ov64), 64'd0);
    check("rst_in_ready64", 64'(rdy64), 64'd1);

    // Latency: accept at edge N, valid after edge N+1
    send32(32'h8000_0000, 5'd4, 3'd2, 5'd0, 32'hF800_0000, 1);
    check("lat_not_yet", 64'(ov32), 64'd0);
    @(posedge clk); #1;
    check("lat_valid", 64'(ov32), 64'd1);
    check("lat_dout", 64'(dout32), 64'hF800_0000);
    drain32();

    // Table-driven directed vectors
    foreach (tab[i]) send32(tab[i].din, tab[i].amt, tab[i].cmd, 5'(i), tab[i].exp, 1);
    drain32();

    // Throughput: 8 random ops back to back
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      a = 5'($urandom_range(0, 31));
      c = 3'($urandom_range(0, 7));
      e = model32(d, int'(a), int'(c));
      send32(d, a, c, 5'(16 + i), e, 1);
    end
    drain32();
    check("tput_count", 64'(pop_cyc.size()), 64'd8);
    if (pop_cyc.size() == 8) check("tput_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

    // Back-pressure: 2 ops fill the pipe, the 3rd is held off
    ordy32 = 1'b0;
    send32(32'h0000_00F0, 5'd4, 3'd1, 5'd1, 32'h0000_000F, 1);
    send32(32'h0000_0003, 5'd2, 3'd0, 5'd2, 32'h0000_000C, 1);
    v32 = 1'b1; din32 = 32'h8000_0001; amt32 = 5'd1; cmd32 = 3'd2; tag32 = 5'd3;
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", 64'(rdy32), 64'd0);
      check("bp_out_valid", 64'(ov32), 64'd1);
      check("bp_dout", 64'(dout32), 64'h0000_000F);
      @(posedge clk); #1;
    end
    ordy32 = 1'b1;
    send32(32'h8000_0001, 5'd1, 3'd2, 5'd3, 32'hC000_0000, 1);
    drain32();

    // Flush with 2 ops in flight and a third offered
    ordy32 = 1'b0;
    send32(32'h1111_1111, 5'd1, 3'd0, 5'd9, 32'h0, 0);
    send32(32'h2222_2222, 5'd1, 3'd0, 5'd10, 32'h0, 0);
    v32 = 1'b1; din32 = 32'h3333_3333; amt32 = 5'd0; cmd32 = 3'd0; tag32 = 5'd11;
    flush32 = 1'b1;
    @(posedge clk); #1;
    flush32 = 1'b0; v32 = 1'b0; ordy32 = 1'b1;
    check("flush_out_valid", 64'(ov32), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("flush_still_empty", 64'(ov32), 64'd0);
    send32(32'h0000_0005, 5'd3, 3'd0, 5'd30, 32'h0000_0028, 1);
    drain32();

    // 64-bit, 3 stages
    run64("w_sra",   64'h0000_0000_8000_0000, 6'd1,  3'd2, 1'b1, 5'd1, 64'hFFFF_FFFF_C000_0000);
    run64("w_sll36", 64'hFFFF_0000_0000_0001, 6'd36, 3'd0, 1'b1, 5'd2, 64'h0000_0000_0000_0010);
    run64("w_srl0",  64'hFFFF_FFFF_8000_0000, 6'd0,  3'd1, 1'b1, 5'd3, 64'hFFFF_FFFF_8000_0000);
    run64("w_srl4",  64'h1234_5678_8000_0000, 6'd4,  3'd1, 1'b1, 5'd4, 64'h0000_0000_0800_0000);
    run64("d_sra63", 64'h8000_0000_0000_0000, 6'd63, 3'd2, 1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    run64("d_sll63", 64'h0000_0000_0000_0001, 6'd63, 3'd0, 1'b0, 5'd6, 64'h8000_0000_0000_0000);
    run64("d_srl32", 64'hFFFF_FFFF_0000_0000, 6'd32, 3'd1, 1'b0, 5'd7, 64'h0000_0000_FFFF_FFFF);
`ifdef SHIFTER_ROTATE_EN
    run64("w_ror8",  64'hAAAA_AAAA_1234_5678, 6'd8,  3'd4, 1'b1, 5'd8, 64'h0000_0000_7812_3456);
`else
    run64("w_ror8",  64'hAAAA_AAAA_1234_5678, 6'd8,  3'd4, 1'b1, 5'd8, 64'h0000_0000_0012_3456);
`endif

    // Reset in the middle of a stall
    ordy64 = 1'b0;
    v64 = 1'b1; din64 = 64'h0F0F_0F0F_0F0F_0F0F; amt64 = 6'd4; cmd64 = 3'd0; word64 = 1'b0; tag64 = 5'h15;
    g = 0;
    do begin
      @(negedge clk); ok = rdy64;
      @(posedge clk); #1; g++;
    end while (!ok && g < 50);
    v64 = 1'b0;
    g = 0;
    while (!ov64 && g < 10) begin @(posedge clk); #1; g++; end
    check("stall_fill64", 64'(ov64), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_out_valid64", 64'(ov64), 64'd0);
    check("midrst_dout64", dout64, 64'd0);
    check("midrst_tag64", 64'(tago64), 64'd0);
    check("midrst_in_ready64", 64'(rdy64), 64'd1);
    check("midrst_out_valid32", 64'(ov32), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    n_bad++;
    $display("FAIL global_timeout: got running, expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "timeout");
  end

endmodule
